regfile_restore: RTL and testbench
==================================

// Module: regfile_restore
// PURPOSE
//  Inverse path of the register-export probe: loads a full GPR snapshot from a host/difftest
//  stream into the register file. Sits between writeback and the regfile write port; stalls the
//  core, waits for it to drain, writes NR_REGS words in index order, then releases the core.
// PARAMETERS
//  NR_REGS  16  number of GPRs (RV32E); power of two, >=2
//  XLEN     32  register width
//  AW       $clog2(NR_REGS)  index width (derived, localparam)
// PORTS
//  clk          in   1     core clock
//  rst_n        in   1     synchronous reset, active-low
//  restore_req  in   1     one-cycle request to start a restore
//  core_idle    in   1     core has no instruction in flight past decode
//  core_stall   out  1     hold core fetch/issue
//  ld_valid     in   1     host word valid
//  ld_ready     out  1     block accepts word this cycle
//  ld_data      in   XLEN  snapshot word; word k targets register k
//  wb_wen       in   1     core writeback enable
//  wb_waddr     in   AW    core writeback index
//  wb_wdata     in   XLEN  core writeback data
//  rf_wen       out  1     regfile write enable
//  rf_waddr     out  AW    regfile write index
//  rf_wdata     out  XLEN  regfile write data
//  busy         out  1     restore in progress (state != IDLE)
//  done         out  1     one-cycle pulse on completion
//  err          out  1     sticky checksum error (0 unless RESTORE_CHECKSUM_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, cnt=0; core_stall, ld_ready, busy, done, err = 0.
//  - States: IDLE -> DRAIN -> LOAD -> (CHECK) -> DONE -> IDLE.
//  - IDLE: rf_* = wb_* pass-through (combinational). restore_req -> DRAIN next cycle.
//    restore_req in any other state ignored.
//  - DRAIN: core_stall=1; wb_* still passes through so in-flight writebacks retire.
//    core_idle=1 -> LOAD, cnt=0.
//  - LOAD: core_stall=1, ld_ready=1; wb_* NOT forwarded (core is drained). Transfer when
//    ld_valid&ld_ready: rf_wen=1, rf_waddr=cnt, rf_wdata=ld_data, same cycle (0 latency); cnt++.
//    Word for index 0 consumed but rf_wen forced 0 (x0 hard-wired). Transfer with
//    cnt==NR_REGS-1 -> DONE (or CHECK). ld_valid low: wait, no write, cnt holds.
//  - DONE: single cycle; done=1, core_stall=1; next IDLE (stall drops with IDLE).
//  - busy=1 in all non-IDLE states. Write latency: register k written in cycle of k-th handshake.
//  - cnt is AW bits, no wrap: leaves LOAD on last index. Stray ld_valid outside LOAD: ld_ready=0,
//    word not consumed.
//  - Mid-restore reset: abort, partially written regs keep loaded values, no done pulse.
// CONFIGURATION
//  RESTORE_CHECKSUM_EN defined: running XOR of all NR_REGS words (incl. word 0); after last
//   word enter CHECK, accept one extra word (ld_ready=1); mismatch sets err (sticky until reset
//   or next restore_req, which clears it); CHECK -> DONE on that handshake. No rf write in CHECK.
//  Not defined: no CHECK state, no XOR logic, err tied 0; exactly NR_REGS words per restore.
// STRUCTURE
//  - regfile_restore_pkg: state enum (IDLE, DRAIN, LOAD, CHECK, DONE), NR_REGS/XLEN defaults.
//  - Sub-module regfile_wr_mux: selects wb_* vs load path onto rf_*, applies x0 suppression.
//  - FSM, counter and checksum in top level.
// TESTING
//  1. Reset held 3 cycles with restore_req=1 -> all outputs 0, state IDLE, rf_* follows wb_*.
//  2. restore_req, core_idle=0 for 4 cycles, wb_wen=1 addr 5 data 0xDEAD -> stall=1, write
//     forwarded; core_idle=1 -> LOAD next cycle.
//  3. Stream words 0x100+k back-to-back -> rf_wen for k=1..15 only, rf_waddr=k, data 0x100+k,
//     done pulses 1 cycle after word 15, stall drops next cycle.
//  4. ld_valid deasserted every other cycle -> cnt holds, no spurious writes, 32-cycle LOAD.
//  5. rst_n low after word 7 -> outputs reset, no done; new restore completes normally.
//  6. (CHECKSUM_EN) correct XOR word -> err=0; corrupted word 0x1 -> err=1 held until next req.

Source files
------------

// File: rtl/regfile_restore_pkg.sv
// Shared definitions for the register-file restore block: default sizing,
// FSM state encoding and small state-decoding helpers.
package regfile_restore_pkg;

  // Default configuration: RV32E register file.
  localparam int NR_REGS_DEF = 16;
  localparam int XLEN_DEF    = 32;

  // FSM encoding kept as plain constants so the state vector stays a simple
  // logic bus in waveforms and in legacy tooling.
  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DRAIN = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Any state other than IDLE means a restore owns the register file.
  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

  // States in which the core's own writeback still reaches the regfile.
  function automatic logic wb_passes(input state_t s);
    return (s == ST_IDLE) || (s == ST_DRAIN);
  endfunction

  // States in which the host stream is accepted.
  function automatic logic accepts_word(input state_t s);
    return (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/regfile_restore_if.sv
// Bus bundle between the restore block and its surroundings (host stream,
// core control, writeback and regfile write port).
// master: the host/core side that drives requests, stream words and writeback.
// slave : the restore block itself.
interface regfile_restore_if
  import regfile_restore_pkg::*;
#(
  parameter int NR_REGS = NR_REGS_DEF,
  parameter int XLEN    = XLEN_DEF
);
  localparam int AW = $clog2(NR_REGS);

  // core control
  logic            restore_req;
  logic            core_idle;
  logic            core_stall;
  // host snapshot stream
  logic            ld_valid;
  logic            ld_ready;
  logic [XLEN-1:0] ld_data;
  // core writeback
  logic            wb_wen;
  logic [AW-1:0]   wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  // regfile write port
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  // status
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output restore_req, core_idle, ld_valid, ld_data, wb_wen, wb_waddr, wb_wdata,
    input  core_stall, ld_ready, rf_wen, rf_waddr, rf_wdata, busy, done, err
  );

  modport slave (
    input  restore_req, core_idle, ld_valid, ld_data, wb_wen, wb_waddr, wb_wdata,
    output core_stall, ld_ready, rf_wen, rf_waddr, rf_wdata, busy, done, err
  );

endinterface

// File: rtl/regfile_wr_mux.sv
// Regfile write-port steering: either the core's writeback passes straight
// through, or the restore load path drives the port. x0 is hard-wired to zero
// in the register file, so a load aimed at index 0 never raises the enable.
module regfile_wr_mux #(
  parameter int AW   = 4,
  parameter int XLEN = 32
) (
  input  logic            pass_wb,
  input  logic            load_wr,
  input  logic [AW-1:0]   load_idx,
  input  logic [XLEN-1:0] load_data,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  // Zero-latency select between writeback and load path, with x0 suppression.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = load_idx;
    rf_wdata = load_data;
    if (pass_wb) begin
      rf_wen   = wb_wen;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else begin
      rf_wen   = load_wr && (load_idx != '0);
    end
  end

endmodule

// File: rtl/regfile_restore.sv
// Register-file restore: stalls the core, waits for it to drain, then writes
// a full GPR snapshot from the host stream into the regfile in index order
// (word k -> register k) and releases the core with a one-cycle done pulse.
//
// Optional feature macro: RESTORE_CHECKSUM_EN
//   When defined, a running XOR of all snapshot words is compared against one
//   extra trailing word; a mismatch sets the sticky err flag, which is cleared
//   by reset or by the next accepted restore request.
module regfile_restore
  import regfile_restore_pkg::*;
#(
  parameter int NR_REGS = NR_REGS_DEF,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_restore_if.slave bus
);

  localparam int            AW       = $clog2(NR_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NR_REGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic ld_ready;
  logic ld_fire;
  logic load_wr;

  assign ld_ready = accepts_word(state_q);
  assign ld_fire  = bus.ld_valid && ld_ready;
  // Only LOAD-state handshakes carry register contents; the CHECK word does not.
  assign load_wr  = (state_q == ST_LOAD) && ld_fire;

  assign bus.ld_ready   = ld_ready;
  assign bus.core_stall = is_busy(state_q);
  assign bus.busy       = is_busy(state_q);
  assign bus.done       = (state_q == ST_DONE);

  // Next-state and index counter; the counter stops on the last index instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.restore_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.core_idle) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          if (cnt_q == LAST_IDX) begin
`ifdef RESTORE_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef RESTORE_CHECKSUM_EN
      ST_CHECK: begin
        if (ld_fire) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and counter registers; reset abandons any restore without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RESTORE_CHECKSUM_EN
  logic [XLEN-1:0] xor_q, xor_d;
  logic            err_q, err_d;

  // Running XOR over the snapshot words and sticky mismatch flag.
  always_comb begin
    xor_d = xor_q;
    err_d = err_q;
    if ((state_q == ST_IDLE) && bus.restore_req) err_d = 1'b0;
    if ((state_q == ST_DRAIN) && bus.core_idle) xor_d = '0;
    if (load_wr) xor_d = xor_q ^ bus.ld_data;
    if ((state_q == ST_CHECK) && ld_fire && (bus.ld_data != xor_q)) err_d = 1'b1;
  end

  // Accumulator is cleared on entry to LOAD, so it needs no reset.
  always_ff @(posedge clk) begin
    xor_q <= xor_d;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  regfile_wr_mux #(
    .AW   (AW),
    .XLEN (XLEN)
  ) u_wr_mux (
    .pass_wb   (wb_passes(state_q)),
    .load_wr   (load_wr),
    .load_idx  (cnt_q),
    .load_data (bus.ld_data),
    .wb_wen    (bus.wb_wen),
    .wb_waddr  (bus.wb_waddr),
    .wb_wdata  (bus.wb_wdata),
    .rf_wen    (bus.rf_wen),
    .rf_waddr  (bus.rf_waddr),
    .rf_wdata  (bus.rf_wdata)
  );

endmodule

// File: tb/tb_regfile_restore.sv
// Bench for regfile_restore: the driver issues restores with randomized drain
// length, stream gaps and writeback noise, and pushes the regfile writes and
// done pulses the snapshot rules call for into a cycle-stamped queue; a
// separate monitor compares every cycle's regfile port and done output
// against that queue.
module tb_regfile_restore;

  localparam int NR = 16;
  localparam int XL = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_restore_if #(.NR_REGS(NR), .XLEN(XL)) bus ();

  regfile_restore #(.NR_REGS(NR), .XLEN(XL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            cyc;
    bit            is_done;
    logic [AW-1:0] addr;
    logic [XL-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc    = 0;
  int  n_vec  = 0;
  int  n_mis  = 0;
  bit  mon_en = 1'b0;
  bit  exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [XL-1:0] d);
    ev_t e;
    e.cyc = cyc; e.is_done = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_done();
    ev_t e;
    e.cyc = cyc; e.is_done = 1'b1; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle, either an expected event is due or the port must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++;
        n_mis++;
        $display("FAIL missed_event: got nothing want %s addr %0d at cycle %0d",
                 exp_q[0].is_done ? "done" : "write", exp_q[0].addr, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_done) begin
          chk("done_pulse", 32'(bus.done), 32'd1);
          chk("done_no_write", 32'(bus.rf_wen), 32'd0);
        end else begin
          chk("rf_wen", 32'(bus.rf_wen), 32'd1);
          chk("rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.addr));
          chk("rf_wdata", bus.rf_wdata, mon_e.data);
          chk("no_done_on_write", 32'(bus.done), 32'd0);
        end
      end else begin
        chk("quiet_wen_done", {30'd0, bus.rf_wen, bus.done}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.restore_req = 1'b0;
    bus.core_idle   = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.wb_wen      = 1'b0;
    bus.wb_waddr    = '0;
    bus.wb_wdata    = '0;
  endtask

  // gap_mode: 0 back-to-back 0x100+k, 1 valid every other cycle, 2 random gaps/data.
  // abort_after: number of words after which reset is pulsed (-1 = none).
  task automatic restore(input int drain_cyc, input int gap_mode, input int abort_after,
                         input bit corrupt);
    logic [XL-1:0] w [NR];
    logic [XL-1:0] x;
    int k, lc;
    bit v;
    x = '0;
    for (int i = 0; i < NR; i++) begin
      w[i] = (gap_mode == 0) ? XL'(32'h100 + i) : XL'($urandom);
      x ^= w[i];
    end
    // Request cycle in IDLE, with a writeback that must pass through.
    bus.restore_req = 1'b1;
    bus.wb_wen      = 1'b1;
    bus.wb_waddr    = AW'($urandom);
    bus.wb_wdata    = XL'($urandom);
    expect_wr(bus.wb_waddr, bus.wb_wdata);
    sample();
    chk("req_stall", 32'(bus.core_stall), 32'd0);
    chk("req_err", 32'(bus.err), 32'(exp_err));
    step();
    exp_err = 1'b0;
    bus.restore_req = 1'b0;
    // DRAIN with core busy: stall raised, writebacks still retire.
    for (int d = 0; d < drain_cyc; d++) begin
      bus.core_idle = 1'b0;
      bus.wb_wen    = 1'b1;
      bus.wb_waddr  = (d == 0) ? AW'(5) : AW'($urandom);
      bus.wb_wdata  = (d == 0) ? XL'(32'hDEAD) : XL'($urandom);
      expect_wr(bus.wb_waddr, bus.wb_wdata);
      sample();
      chk("drain_stall", 32'(bus.core_stall), 32'd1);
      chk("drain_busy", 32'(bus.busy), 32'd1);
      chk("drain_ld_ready", 32'(bus.ld_ready), 32'd0);
      step();
    end
    // Core reports idle; a stray stream word here must not be taken.
    bus.core_idle = 1'b1;
    bus.wb_wen    = 1'b0;
    bus.ld_valid  = 1'b1;
    bus.ld_data   = XL'($urandom);
    sample();
    chk("drain_stray_ready", 32'(bus.ld_ready), 32'd0);
    chk("drain_err_cleared", 32'(bus.err), 32'd0);
    step();
    // LOAD: stream the snapshot; writebacks and requests must be ignored.
    k = 0;
    lc = 0;
    while (k < NR) begin
      bus.core_idle   = 1'($urandom);
      bus.restore_req = 1'($urandom);
      bus.wb_wen      = 1'b1;
      bus.wb_waddr    = AW'($urandom);
      bus.wb_wdata    = XL'($urandom);
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (lc % 2 == 1) : ($urandom_range(0, 2) != 0);
      bus.ld_valid = v;
      bus.ld_data  = v ? w[k] : XL'($urandom);
      if (v && k != 0) expect_wr(AW'(k), w[k]);
      sample();
      chk("load_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("load_stall", 32'(bus.core_stall), 32'd1);
      step();
      lc++;
      if (v) begin
        k++;
        if (k == abort_after) begin
          idle_inputs();
          rst_n = 1'b0;
          sample();
          step();
          rst_n = 1'b1;
          sample();
          chk("abort_stall", 32'(bus.core_stall), 32'd0);
          chk("abort_busy", 32'(bus.busy), 32'd0);
          chk("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
          chk("abort_err", 32'(bus.err), 32'd0);
          step();
          return;
        end
      end
    end
    if (gap_mode == 1) chk("load_cycles", 32'(lc), 32'(2 * NR));
`ifdef RESTORE_CHECKSUM_EN
    idle_inputs();
    bus.ld_valid = 1'b1;
    bus.ld_data  = corrupt ? (x ^ XL'(1)) : x;
    sample();
    chk("check_ld_ready", 32'(bus.ld_ready), 32'd1);
    step();
    exp_err = corrupt;
`else
    if (corrupt) chk("corrupt_needs_checksum", 32'(x == x), 32'd0);
`endif
    // DONE: one-cycle pulse; stray word and request both ignored.
    idle_inputs();
    bus.ld_valid    = 1'b1;
    bus.restore_req = 1'b1;
    expect_done();
    sample();
    chk("done_stall", 32'(bus.core_stall), 32'd1);
    chk("done_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    step();
    // Back in IDLE: stall released.
    idle_inputs();
    sample();
    chk("post_stall", 32'(bus.core_stall), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_err", 32'(bus.err), 32'(exp_err));
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus.restore_req = 1'b1;
    step();
    mon_en = 1'b1;
    // Reset held with a pending request: everything quiet, writeback passes.
    for (int r = 0; r < 3; r++) begin
      bus.wb_wen   = 1'b1;
      bus.wb_waddr = AW'(r + 2);
      bus.wb_wdata = XL'($urandom);
      expect_wr(bus.wb_waddr, bus.wb_wdata);
      sample();
      chk("rst_stall", 32'(bus.core_stall), 32'd0);
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    sample();
    chk("post_rst_stall", 32'(bus.core_stall), 32'd0);
    step();

    restore(4, 0, -1, 1'b0);
    restore(1, 1, -1, 1'b0);
    restore(0, 2, 8, 1'b0);
    restore(2, 2, -1, 1'b0);
`ifdef RESTORE_CHECKSUM_EN
    restore(1, 2, -1, 1'b1);
    restore(0, 0, -1, 1'b0);
`endif
    for (int i = 0; i < 3; i++) restore($urandom_range(0, 3), 2, -1, 1'b0);

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
